// File: rtl/instruction_fetch.sv
// Single-issue instruction fetch stage. Keeps one word in flight to a one-cycle-latency program
// memory and redirects on rjmp/ijmp with no bubbles. Supports downstream stall and skip-next.
module instruction_fetch (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_pmem_addr,
    input  logic [15:0] i_pmem_data,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_stall,
    input  logic        i_skip,
    input  logic [15:0] i_z
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] fa_q;
    logic [15:0] fa_d;
    logic        fv_q;
    logic        fv_d;
    logic        skip_pending_q;
    logic        skip_pending_d;

    logic        instr_valid_s;
    logic        accept_s;
    logic        squash_s;
    logic        hold_s;
    logic        rjmp_s;
    logic        ijmp_s;
    logic        redirect_s;
    logic [15:0] rjmp_target_s;
    logic [15:0] jump_target_s;
    logic [15:0] fetch_addr_s;

    // Handshake qualification and jump decode of the word currently presented.
    always_comb begin
        instr_valid_s = fv_q & ~skip_pending_q;
        accept_s      = instr_valid_s & ~i_stall;
        squash_s      = fv_q & skip_pending_q;
        hold_s        = instr_valid_s & i_stall;
        rjmp_s        = (i_pmem_data[15:12] == 4'hC);
        ijmp_s        = (i_pmem_data == 16'h9409);
        redirect_s    = accept_s & (rjmp_s | ijmp_s);
        // Relative offset is a signed 12-bit word count from the following address.
        rjmp_target_s = fa_q + 16'd1 + {{4{i_pmem_data[11]}}, i_pmem_data[11:0]};
        if (ijmp_s) begin
            jump_target_s = i_z;
        end else begin
            jump_target_s = rjmp_target_s;
        end
    end

    // Address selection: re-fetch the held word, follow a jump, or continue sequentially.
    always_comb begin
        if (hold_s) begin
            fetch_addr_s = fa_q;
        end else if (redirect_s) begin
            fetch_addr_s = jump_target_s;
        end else begin
            fetch_addr_s = pc_q;
        end
    end

    // Next-state computation for the fetch pointers and the skip tracker.
    always_comb begin
        fa_d = fetch_addr_s;
        pc_d = fetch_addr_s + 16'd1;
        fv_d = 1'b1;
        if (squash_s) begin
            skip_pending_d = 1'b0;
        end else if (accept_s && i_skip) begin
            skip_pending_d = 1'b1;
        end else begin
            skip_pending_d = skip_pending_q;
        end
    end

    // State registers; reset forces an idle pipeline fetching from address zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q           <= 16'h0000;
            fa_q           <= 16'h0000;
            fv_q           <= 1'b0;
            skip_pending_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            fa_q           <= fa_d;
            fv_q           <= fv_d;
            skip_pending_q <= skip_pending_d;
        end
    end

    assign o_pmem_addr   = fetch_addr_s;
    assign o_instr       = i_pmem_data;
    assign o_instr_pc    = fa_q;
    assign o_instr_valid = instr_valid_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic, checked against an
// instruction-stream model that tracks which address is presented next and whether it is live.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pmem_addr;
    logic [15:0] pmem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        skip = 1'b0;
    logic [15:0] z = 16'h0000;

    logic [15:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    localparam int K_RESET  = 0;
    localparam int K_VALID  = 1;
    localparam int K_SQUASH = 2;

    int          m_kind = K_RESET;
    logic [15:0] m_pc   = 16'h0000;

    always #5 clk = ~clk;

    // Program memory: one-cycle read latency.
    always @(posedge clk) pmem_data <= mem[pmem_addr];

    instruction_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_pmem_addr   (pmem_addr),
        .i_pmem_data   (pmem_data),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .i_stall       (stall),
        .i_skip        (skip),
        .i_z           (z)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Where control goes after the word w at address pc is accepted.
    function automatic logic [15:0] model_target(input logic [15:0] pc, input logic [15:0] w,
                                                 input logic [15:0] zz);
        int off;
        int t;
        if (w[15:12] == 4'hC) begin
            off = int'(w[11:0]);
            if (off >= 2048) off = off - 4096;
            t = int'(pc) + 1 + off;
            return t[15:0];
        end else if (w == 16'h9409) begin
            return zz;
        end else begin
            return pc + 16'd1;
        end
    endfunction

    task automatic observe();
        logic [15:0] nxt;
        int          nk;
        chk("valid", {15'd0, instr_valid}, {15'd0, (m_kind == K_VALID)});
        chk("instr_pc", instr_pc, m_pc);
        if (m_kind == K_VALID) chk("instr", instr, mem[m_pc]);
        case (m_kind)
            K_RESET: begin
                nxt = 16'h0000;
                nk  = K_VALID;
            end
            K_SQUASH: begin
                nxt = m_pc + 16'd1;
                nk  = K_VALID;
            end
            default: begin
                if (stall) begin
                    nxt = m_pc;
                    nk  = K_VALID;
                end else begin
                    nxt = model_target(m_pc, mem[m_pc], z);
                    nk  = skip ? K_SQUASH : K_VALID;
                end
            end
        endcase
        chk("pmem_addr", pmem_addr, nxt);
        m_pc   = nxt;
        m_kind = nk;
    endtask

    task automatic step(input logic st, input logic sk, input logic [15:0] zz);
        @(negedge clk);
        stall = st;
        skip  = sk;
        z     = zz;
        #1;
        observe();
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", pmem_addr, 16'h0000);
        chk("rst_pc", instr_pc, 16'h0000);
        chk("rst_valid", {15'd0, instr_valid}, 16'h0000);
        m_kind = K_RESET;
        m_pc   = 16'h0000;
        stall  = 1'b0;
        skip   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        observe();
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 65536; i++) begin
            mem[i[15:0]] = 16'h1000 | 16'(i & 32'h0FFF);
        end
    endtask

    task automatic fill_rand();
        logic [15:0] w;
        int          r;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) w[15:12] = 4'hC;
            if (r == 1) w = 16'h9409;
            mem[i[15:0]] = w;
        end
    endtask

    initial begin
        // Sequential fetch from reset.
        fill_seq();
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("seq_pc2", instr_pc, 16'h0002);
        chk("seq_addr3", pmem_addr, 16'h0003);

        // Forward rjmp at address 0.
        fill_seq();
        mem[16'h0000] = 16'hC003;
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        chk("rjmp_addr", pmem_addr, 16'h0004);
        step(1'b0, 1'b0, 16'h0000);
        chk("rjmp_pc", instr_pc, 16'h0004);
        chk("rjmp_valid", {15'd0, instr_valid}, 16'h0001);

        // Self-loop rjmp at 3, escaped by skip, then ijmp at 4.
        fill_seq();
        mem[16'h0003] = 16'hCFFF;
        mem[16'h0004] = 16'h9409;
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("loop_pc", instr_pc, 16'h0003);
        step(1'b0, 1'b0, 16'h0000);
        chk("loop_pc_again", instr_pc, 16'h0003);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0010);
        chk("ijmp_addr", pmem_addr, 16'h0010);
        step(1'b0, 1'b0, 16'h0000);
        chk("ijmp_pc", instr_pc, 16'h0010);

        // Three-cycle stall while pc=1.
        fill_seq();
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        chk("stall_addr", pmem_addr, 16'h0001);
        chk("stall_instr", instr, 16'h1001);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("stall_release_pc", instr_pc, 16'h0002);

        // Skip squashes a jump word; squash cycle ignores stall; skip under stall is ignored.
        fill_seq();
        mem[16'h0002] = 16'hC003;
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        chk("squash_pc", instr_pc, 16'h0002);
        chk("squash_addr", pmem_addr, 16'h0003);
        step(1'b1, 1'b1, 16'h0000);
        chk("after_squash_pc", instr_pc, 16'h0003);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("stall_skip_ignored", {15'd0, instr_valid}, 16'h0001);

        // Reset while a redirect is being driven.
        fill_seq();
        mem[16'h0000] = 16'hC003;
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        do_reset();
        step(1'b0, 1'b0, 16'h0000);

        // Reset while a skip is pending, then check no residual squash.
        fill_seq();
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        do_reset();
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk("no_residual_skip", {15'd0, instr_valid}, 16'h0001);

        // rjmp with zero offset at 0xFFFF wraps to 0x0000.
        fill_seq();
        mem[16'h0000] = 16'h9409;
        mem[16'hFFFF] = 16'hC000;
        do_reset();
        step(1'b0, 1'b0, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000);
        chk("wrap_addr", pmem_addr, 16'h0000);
        step(1'b0, 1'b0, 16'h0008);
        chk("wrap_pc", instr_pc, 16'h0000);

        // Randomized traffic over a random program image.
        fill_rand();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
